// File: rtl/debounce_scheduler_pkg.sv
// debounce_pkg: shared FSM state, synchronizer depth and index-width helper for debounce_scheduler.
package debounce_pkg;
   typedef enum logic {IDLE, SCAN} state_t;
   localparam int SYNC_STAGES = 2;
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/debounce_scheduler_if.sv
// debounce_scheduler_if: button/enable inputs and filtered/status outputs of debounce_scheduler.
// DEBOUNCE_SCHED_EDGE_EN adds the rise/fall pulse outputs.
interface debounce_scheduler_if #(
   parameter int N_CH = 3
);
   logic            en;
   logic [N_CH-1:0] button;
   logic [N_CH-1:0] debounced;
   logic            scan_busy;
   logic            scan_done;
   logic            overrun;
`ifdef DEBOUNCE_SCHED_EDGE_EN
   logic [N_CH-1:0] rise;
   logic [N_CH-1:0] fall;
   modport master (output en, button, input debounced, scan_busy, scan_done, overrun, rise, fall);
   modport slave (input en, button, output debounced, scan_busy, scan_done, overrun, rise, fall);
`else
   modport master (output en, button, input debounced, scan_busy, scan_done, overrun);
   modport slave (input en, button, output debounced, scan_busy, scan_done, overrun);
`endif
endinterface

// File: rtl/debounce_scheduler_prescaler.sv
// debounce_prescaler: enable-gated sample-tick generator, one tick every PRESCALE enabled clocks.
module debounce_prescaler
   import debounce_pkg::*;
#(
   parameter int PRESCALE = 1000
) (
   input  logic clk,
   input  logic reset,
   input  logic i_en,
   output logic o_tick
);
   localparam int CNT_W = idx_w(PRESCALE);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);
   logic [CNT_W-1:0] r_count;
   always_ff @(posedge clk) begin
      if (reset) r_count <= '0;
      else if (i_en) r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
   end
   assign o_tick = i_en && (r_count == LAST);
endmodule

// File: rtl/debounce_scheduler.sv
// debounce_scheduler: round-robin debouncer sharing one prescaler and one all-0/all-1 comparator.
// Define DEBOUNCE_SCHED_EDGE_EN to add registered rise/fall pulses.
module debounce_scheduler
   import debounce_pkg::*;
#(
   parameter int N_CH     = 3,
   parameter int HIST     = 8,
   parameter int PRESCALE = 1000
) (
   input logic                 clk,
   input logic                 reset,
   debounce_scheduler_if.slave bus
);
   localparam int IDX_W = idx_w(N_CH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);
   logic [SYNC_STAGES-1:0][N_CH-1:0] r_sync;
   logic [HIST-1:0]                  r_hist [N_CH];
   logic [N_CH-1:0]                  r_debounced;
   state_t                           r_state;
   logic [IDX_W-1:0]                 r_idx;
   logic                             r_scan_busy;
   logic                             r_scan_done;
   logic                             r_overrun;
   logic                             w_tick;
   logic [HIST-1:0]                  w_new_hist;
   debounce_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
      .clk    (clk),
      .reset  (reset),
      .i_en   (bus.en),
      .o_tick (w_tick)
   );
   // The single shared comparator looks at the history of the channel being scanned.
   assign w_new_hist = {r_hist[r_idx][HIST-2:0], r_sync[SYNC_STAGES-1][r_idx]};
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync      <= '0;
         for (int i = 0; i < N_CH; i++) r_hist[i] <= '0;
         r_debounced <= '0;
         r_state     <= IDLE;
         r_idx       <= '0;
         r_scan_busy <= 1'b0;
         r_scan_done <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_sync      <= {r_sync[SYNC_STAGES-2:0], bus.button};
         r_scan_done <= 1'b0;
         if (w_tick && r_state == SCAN) r_overrun <= 1'b1;
         if (r_state == IDLE) begin
            if (w_tick) begin
               r_state     <= SCAN;
               r_idx       <= '0;
               r_scan_busy <= 1'b1;
            end
         end else begin
            r_hist[r_idx] <= w_new_hist;
            if (&w_new_hist) r_debounced[r_idx] <= 1'b1;
            else if (~|w_new_hist) r_debounced[r_idx] <= 1'b0;
            r_idx <= r_idx + 1'b1;
            if (r_idx == LAST_IDX) begin
               r_state     <= IDLE;
               r_idx       <= '0;
               r_scan_busy <= 1'b0;
               r_scan_done <= 1'b1;
            end
         end
      end
   end
   assign bus.debounced = r_debounced;
   assign bus.scan_busy = r_scan_busy;
   assign bus.scan_done = r_scan_done;
   assign bus.overrun   = r_overrun;
`ifdef DEBOUNCE_SCHED_EDGE_EN
   logic [N_CH-1:0] r_prev;
   logic [N_CH-1:0] r_rise;
   logic [N_CH-1:0] r_fall;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_prev <= '0;
         r_rise <= '0;
         r_fall <= '0;
      end else begin
         r_prev <= r_debounced;
         r_rise <= r_debounced & ~r_prev;
         r_fall <= ~r_debounced & r_prev;
      end
   end
   assign bus.rise = r_rise;
   assign bus.fall = r_fall;
`endif
endmodule

// File: tb/tb_debounce_scheduler.sv
// tb_debounce_scheduler: randomized scoreboard bench with a sample-run reference model.
// Runs a PRESCALE=8 instance, then a PRESCALE=2 instance for overrun behaviour.
module tb_debounce_scheduler;
   localparam int N = 3;
   localparam int HIST = 4;
   typedef struct {
      int           due;
      logic [N-1:0] deb;
      logic         ovr;
   } sb_t;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;
   bit   sel = 1'b0;
   debounce_scheduler_if #(.N_CH(N)) ia ();
   debounce_scheduler_if #(.N_CH(N)) ib ();
   debounce_scheduler #(.N_CH(N), .HIST(HIST), .PRESCALE(8)) dut_a (.clk(clk), .reset(rst_a), .bus(ia));
   debounce_scheduler #(.N_CH(N), .HIST(HIST), .PRESCALE(2)) dut_b (.clk(clk), .reset(rst_b), .bus(ib));
   logic [N-1:0] m_deb;
   logic         m_busy, m_done, m_ovr;
   assign m_deb  = sel ? ib.debounced : ia.debounced;
   assign m_busy = sel ? ib.scan_busy : ia.scan_busy;
   assign m_done = sel ? ib.scan_done : ia.scan_done;
   assign m_ovr  = sel ? ib.overrun : ia.overrun;
`ifdef DEBOUNCE_SCHED_EDGE_EN
   logic [N-1:0] m_rise, m_fall;
   assign m_rise = sel ? ib.rise : ia.rise;
   assign m_fall = sel ? ib.fall : ia.fall;
`endif
   int checks = 0;
   int failures = 0;
   // Reference model: counts consecutive equal samples per channel.
   int           cyc = 0;
   int           P = 8;
   int           ecount, start;
   int           run1 [N];
   int           run0 [N];
   bit           active, movr, seen_reset, e_valid;
   logic [N-1:0] mdeb, pr1, pr2, pf1, pf2;
   logic [N-1:0] bh [8192];
   logic [N-1:0] e_deb, e_rise, e_fall;
   logic         e_busy, e_ovr;
   sb_t          sbq [$];
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask
   task automatic model_clear();
      ecount = 0;
      active = 1'b0;
      movr   = 1'b0;
      mdeb   = '0;
      pr1 = '0; pr2 = '0; pf1 = '0; pf2 = '0;
      for (int i = 0; i < N; i++) begin
         run1[i] = 0;
         run0[i] = 0;
      end
   endtask
   task automatic step(input logic rs, input logic e, input logic [N-1:0] b);
      bit scanning, push;
      int i;
      @(posedge clk);
      #1;
      cyc++;
      rst_a = sel ? 1'b1 : rs;
      rst_b = sel ? rs : 1'b1;
      ia.en = e; ib.en = e;
      ia.button = b; ib.button = b;
      bh[cyc % 8192] = b;
      scanning = active && cyc >= start + 1 && cyc <= start + N;
      e_valid = seen_reset;
      if (rs) seen_reset = 1'b1;
      e_busy = scanning; e_deb = mdeb; e_ovr = movr; e_rise = pr1; e_fall = pf1;
      pr1 = pr2; pf1 = pf2; pr2 = '0; pf2 = '0;
      push = 1'b0;
      if (rs) model_clear();
      else begin
         if (scanning) begin
            i = cyc - start - 1;
            if (bh[(cyc - 2) % 8192][i]) begin run1[i]++; run0[i] = 0; end
            else begin run0[i]++; run1[i] = 0; end
            if (run1[i] >= HIST && !mdeb[i]) begin mdeb[i] = 1'b1; pr2[i] = 1'b1; end
            if (run0[i] >= HIST && mdeb[i]) begin mdeb[i] = 1'b0; pf2[i] = 1'b1; end
            if (i == N - 1) begin active = 1'b0; push = 1'b1; end
         end
         if (e && ecount % P == P - 1) begin
            if (scanning) movr = 1'b1;
            else begin active = 1'b1; start = cyc; end
         end
         if (e) ecount++;
         if (push) sbq.push_back('{cyc + 1, mdeb, movr});
      end
   endtask
   // Monitor: per-cycle state checks plus scoreboard pop on every scan_done.
   always @(negedge clk) begin
      if (e_valid) begin
         bit  due_now;
         sb_t it;
         chk("scan_busy", int'(m_busy), int'(e_busy));
         chk("debounced", int'(m_deb), int'(e_deb));
         chk("overrun", int'(m_ovr), int'(e_ovr));
`ifdef DEBOUNCE_SCHED_EDGE_EN
         chk("rise", int'(m_rise), int'(e_rise));
         chk("fall", int'(m_fall), int'(e_fall));
`endif
         due_now = sbq.size() > 0 && sbq[0].due == cyc;
         if (m_done || due_now) begin
            chk("scan_done", int'(m_done), int'(due_now));
            if (due_now) begin
               it = sbq.pop_front();
               chk("done_deb", int'(m_deb), int'(it.deb));
               chk("done_ovr", int'(m_ovr), int'(it.ovr));
            end
         end
      end
   end
   task automatic rand_steps(input int n, input bit en_always);
      logic [N-1:0] b;
      int j;
      b = ia.button;
      for (int k = 0; k < n; k++) begin
         if ($urandom_range(0, 5) == 0) begin
            j = $urandom_range(0, N - 1);
            b[j] = ~b[j];
         end
         step(1'b0, en_always || $urandom_range(0, 9) != 0, b);
      end
   endtask
   initial begin
      int first, nbusy, done_at;
      model_clear();
      repeat (3) step(1'b1, 1'b1, 3'b111);
      @(negedge clk);
      chk("reset_outputs", int'({m_ovr, m_done, m_busy, m_deb}), 0);
      first = 0; nbusy = 0; done_at = 0;
      for (int k = 1; k <= 12; k++) begin
         step(1'b0, 1'b1, 3'b000);
         @(negedge clk);
         if (m_busy) begin
            nbusy++;
            if (first == 0) first = k;
         end
         if (m_done && done_at == 0) done_at = k;
      end
      chk("first_busy", first, 9);
      chk("busy_len", nbusy, 3);
      chk("done_at", done_at, 12);
      repeat (20) step(1'b0, 1'b1, 3'b000);
      repeat (64) step(1'b0, 1'b1, 3'b010);
      @(negedge clk);
      chk("press", int'(m_deb), 2);
      for (int k = 0; k < 60; k++) step(1'b0, 1'b1, {2'b01, 1'((k / 5) % 2)});
      @(negedge clk);
      chk("bounce_held_off", int'(m_deb), 2);
      repeat (64) step(1'b0, 1'b1, 3'b011);
      @(negedge clk);
      chk("bounce_settle", int'(m_deb), 3);
      repeat (64) step(1'b0, 1'b1, 3'b001);
      @(negedge clk);
      chk("release", int'(m_deb), 1);
      nbusy = 0;
      for (int k = 0; k < 50; k++) begin
         step(1'b0, 1'b0, 3'b100);
         @(negedge clk);
         if (k >= 5 && m_busy) nbusy++;
      end
      chk("en_off_busy", nbusy, 0);
      chk("en_off_frozen", int'(m_deb), 1);
      repeat (48) step(1'b0, 1'b1, 3'b100);
      @(negedge clk);
      chk("en_resume", int'(m_deb), 4);
      rand_steps(200, 1'b0);
      step(1'b1, 1'b1, 3'b000);
      rand_steps(200, 1'b0);
      @(negedge clk);
      #1;
      sel = 1'b1;
      P = 2;
      model_clear();
      repeat (3) step(1'b1, 1'b1, 3'b000);
      rand_steps(20, 1'b1);
      @(negedge clk);
      chk("overrun_set", int'(m_ovr), 1);
      rand_steps(100, 1'b0);
      @(negedge clk);
      chk("overrun_sticky", int'(m_ovr), 1);
      for (int k = 0; k < 10 && !e_busy; k++) rand_steps(1, 1'b1);
      step(1'b1, 1'b1, 3'b111);
      step(1'b0, 1'b1, 3'b111);
      @(negedge clk);
      chk("reset_mid_scan", int'({m_ovr, m_busy, m_deb}), 0);
      repeat (40) step(1'b0, 1'b1, 3'b111);
      rand_steps(60, 1'b0);
      repeat (6) step(1'b0, 1'b1, ib.button);
      @(negedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
